// File: rtl/taiko_draw_pkg.sv
// Shared definitions for the frame draw path: command codes, note types,
// per-command dwell lengths and the sequencer state encoding.
package taiko_draw_pkg;

   localparam logic [4:0] CMD_BG        = 5'h01;
   localparam logic [4:0] CMD_NOTE_BASE = 5'h02;
   localparam logic [4:0] CMD_DIGIT1    = 5'h11;
   localparam logic [4:0] CMD_DIGIT2    = 5'h12;
   localparam logic [4:0] CMD_BG2       = 5'h13;
   localparam logic [4:0] CMD_CLEAR     = 5'h14;
   localparam logic [4:0] CMD_PLOT      = 5'h15;
   localparam logic [4:0] CMD_NOP       = 5'h16;
   localparam logic [4:0] CMD_LINE1     = 5'h17;
   localparam logic [4:0] CMD_LINE2     = 5'h18;
   localparam logic [4:0] CMD_LINE3     = 5'h19;

   localparam logic [2:0] NOTE_NONE = 3'd0;
   localparam logic [2:0] RED_S     = 3'd1;
   localparam logic [2:0] BLUE_S    = 3'd2;
   localparam logic [2:0] RED_B     = 3'd3;
   localparam logic [2:0] BLUE_B    = 3'd4;

   localparam logic [11:0] CLEAR_CYCLES = 12'd2268;
   localparam logic [11:0] STRIP_CYCLES = 12'd16;
   localparam logic [11:0] SMALL_CYCLES = 12'd81;
   localparam logic [11:0] BIG_CYCLES   = 12'd169;
   localparam logic [11:0] DIGIT_CYCLES = 12'd35;
   localparam logic [11:0] LINE_CYCLES  = 12'd16;

   localparam logic [3:0] LAST_NOTE_IDX  = 4'd15;
   localparam logic [3:0] LAST_FACE_IDX  = 4'd10;
   localparam logic [3:0] LAST_DIGIT_IDX = 4'd1;
   localparam logic [3:0] LAST_LINE_IDX  = 4'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_NOTE,
      ST_DIGIT,
      ST_LINE,
      ST_DONE
   } draw_state_t;

   // States whose command actually writes pixels.
   function automatic logic is_drawing(input draw_state_t st);
      return (st == ST_CLEAR) || (st == ST_NOTE) || (st == ST_DIGIT) || (st == ST_LINE);
   endfunction

endpackage

// File: rtl/note_dwell_lut.sv
// Pixel count of one note slot. Only slots 1..10 can hold a face; slots
// 11..15 are always drawn as a plain strip whatever their type.
module note_dwell_lut
   import taiko_draw_pkg::*;
(
   input  logic [3:0]  idx,
   input  logic [2:0]  note_type,
   output logic [11:0] dwell
);

   // Strip for empty/late slots, small face for the two small types, big otherwise.
   always_comb begin
      dwell = BIG_CYCLES;
      if (idx > LAST_FACE_IDX || note_type == NOTE_NONE) begin
         dwell = STRIP_CYCLES;
      end else if (note_type == RED_S || note_type == BLUE_S) begin
         dwell = SMALL_CYCLES;
      end
   end

endmodule

// File: rtl/draw_command_sequencer.sv
// Frame draw program: clear strip, 15 notes, 2 score digits, 3 drum lines.
//
// state | meaning
// IDLE  | NOP on the bus, waiting for frame_tick
// CLEAR | strip clear, CLEAR_CYCLES pixels
// NOTE  | note idx (1..15), dwell from the note type latched on entry
// DIGIT | score digit idx (0..1)
// LINE  | drum line idx (0..2)
// DONE  | single NOP cycle flagging frame_done
module draw_command_sequencer
   import taiko_draw_pkg::*;
(
   input  logic        CLK,
   input  logic        reset,
   input  logic        enable,
   input  logic        frame_tick,
   input  logic [44:0] note_types,
   output logic [4:0]  command,
   output logic        plot,
   output logic        busy,
   output logic        frame_done,
   output logic        overrun
);

   draw_state_t state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic [11:0] cnt_q, cnt_d;
   logic [2:0]  type_q, type_d;
   logic [11:0] note_dwell;
   logic [11:0] dwell;
   logic        last_pixel;
   logic [2:0]  note_type_at [16];

   note_dwell_lut u_note_dwell_lut (
      .idx       (idx_q),
      .note_type (type_q),
      .dwell     (note_dwell)
   );

   // Unpack the 15 three-bit note types; slot 0 is unused padding.
   always_comb begin
      note_type_at[0] = NOTE_NONE;
      for (int n = 1; n < 16; n++) begin
         note_type_at[n] = note_types[3*n-3 +: 3];
      end
   end

   // Dwell of the command currently on the bus and its terminal-count compare.
   always_comb begin
      dwell = 12'd1;
      unique case (state_q)
         ST_CLEAR: dwell = CLEAR_CYCLES;
         ST_NOTE:  dwell = note_dwell;
         ST_DIGIT: dwell = DIGIT_CYCLES;
         ST_LINE:  dwell = LINE_CYCLES;
         default:  dwell = 12'd1;
      endcase
      last_pixel = (cnt_q == dwell - 12'd1);
   end

   // Next state; everything freezes while enable is low.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      type_d  = type_q;
      if (enable) begin
         unique case (state_q)
            ST_IDLE: begin
               if (frame_tick) begin
                  state_d = ST_CLEAR;
                  idx_d   = 4'd0;
                  cnt_d   = 12'd0;
               end
            end
            ST_CLEAR: begin
               if (last_pixel) begin
                  state_d = ST_NOTE;
                  idx_d   = 4'd1;
                  cnt_d   = 12'd0;
                  type_d  = note_type_at[1];
               end else begin
                  cnt_d = cnt_q + 12'd1;
               end
            end
            ST_NOTE: begin
               if (last_pixel) begin
                  cnt_d = 12'd0;
                  if (idx_q == LAST_NOTE_IDX) begin
                     state_d = ST_DIGIT;
                     idx_d   = 4'd0;
                  end else begin
                     idx_d  = idx_q + 4'd1;
                     type_d = note_type_at[idx_q + 4'd1];
                  end
               end else begin
                  cnt_d = cnt_q + 12'd1;
               end
            end
            ST_DIGIT: begin
               if (last_pixel) begin
                  cnt_d = 12'd0;
                  if (idx_q == LAST_DIGIT_IDX) begin
                     state_d = ST_LINE;
                     idx_d   = 4'd0;
                  end else begin
                     idx_d = idx_q + 4'd1;
                  end
               end else begin
                  cnt_d = cnt_q + 12'd1;
               end
            end
            ST_LINE: begin
               if (last_pixel) begin
                  cnt_d = 12'd0;
                  if (idx_q == LAST_LINE_IDX) begin
                     state_d = ST_DONE;
                     idx_d   = 4'd0;
                  end else begin
                     idx_d = idx_q + 4'd1;
                  end
               end else begin
                  cnt_d = cnt_q + 12'd1;
               end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Command bus and status decoded from the held state.
   always_comb begin
      command    = CMD_NOP;
      busy       = (state_q != ST_IDLE);
      frame_done = (state_q == ST_DONE);
      unique case (state_q)
         ST_CLEAR: command = CMD_CLEAR;
         ST_NOTE:  command = CMD_NOTE_BASE + {1'b0, idx_q} - 5'd1;
         ST_DIGIT: command = (idx_q == 4'd0) ? CMD_DIGIT1 : CMD_DIGIT2;
         ST_LINE:  command = CMD_LINE1 + {1'b0, idx_q};
         default:  command = CMD_NOP;
      endcase
   end

   // Sequencer registers.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         idx_q   <= 4'd0;
         cnt_q   <= 12'd0;
         type_q  <= NOTE_NONE;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         type_q  <= type_d;
      end
   end

   // plot trails the command by one cycle to line up with the Processor's
   // registered pixel outputs; overrun latches any tick that lands mid-frame.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         plot    <= 1'b0;
         overrun <= 1'b0;
      end else begin
         plot    <= enable && is_drawing(state_q);
         overrun <= overrun || (frame_tick && busy);
      end
   end

endmodule

// File: tb/tb_draw_command_sequencer.sv
// Scoreboard bench: stimulus queues the expected (command, dwell) segments
// and frame lengths; a negedge monitor checks them as the DUT produces them.
module tb_draw_command_sequencer;

   logic        CLK = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        frame_tick = 1'b0;
   logic [44:0] note_types = '0;
   logic [4:0]  command;
   logic        plot;
   logic        busy;
   logic        frame_done;
   logic        overrun;

   draw_command_sequencer dut (
      .CLK        (CLK),
      .reset      (reset),
      .enable     (enable),
      .frame_tick (frame_tick),
      .note_types (note_types),
      .command    (command),
      .plot       (plot),
      .busy       (busy),
      .frame_done (frame_done),
      .overrun    (overrun)
   );

   always #10 CLK = ~CLK;

   typedef struct {
      logic [4:0] cmd;
      int         len;
   } seg_t;

   seg_t seg_q[$];
   int   frame_q[$];
   int   tests = 0;
   int   errors = 0;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // Monitor: closes a command segment whenever the bus changes, counting only
   // enabled cycles, and checks frame length on each frame_done.
   logic [4:0] cur_cmd = 5'h16;
   int         run_len = 0;
   int         busy_cnt = 0;
   seg_t       exp_seg;
   int         exp_len;

   always @(negedge CLK) begin
      if (reset) begin
         cur_cmd  = 5'h16;
         run_len  = 0;
         busy_cnt = 0;
      end else begin
         if (command != cur_cmd) begin
            if (cur_cmd != 5'h16) begin
               if (seg_q.size() == 0) begin
                  tests++;
                  errors++;
                  $display("FAIL seg_unexpected: got cmd 0x%0h len %0d, expected no segment", cur_cmd, run_len);
               end else begin
                  exp_seg = seg_q.pop_front();
                  check("seg_cmd", int'(cur_cmd), int'(exp_seg.cmd));
                  check("seg_len", run_len, exp_seg.len);
               end
            end
            cur_cmd = command;
            run_len = 0;
         end
         if (enable) run_len++;
         if (busy) busy_cnt++;
         else busy_cnt = 0;
         if (frame_done) begin
            if (frame_q.size() == 0) begin
               tests++;
               errors++;
               $display("FAIL frame_done_unexpected: got pulse after %0d busy cycles, expected none", busy_cnt);
            end else begin
               exp_len = frame_q.pop_front();
               check("frame_len", busy_cnt, exp_len);
            end
         end
      end
   end

   task automatic push_seg(input logic [4:0] c, input int l);
      seg_t s;
      s.cmd = c;
      s.len = l;
      seg_q.push_back(s);
   endtask

   // Expected program: note 1 and note 2 dwell given, notes 3..15 are strips.
   task automatic push_frame(input int n1, input int n2, input int flen);
      push_seg(5'h14, 2268);
      push_seg(5'h02, n1);
      push_seg(5'h03, n2);
      for (int c = 4; c <= 16; c++) push_seg(5'(c), 16);
      push_seg(5'h11, 35);
      push_seg(5'h12, 35);
      push_seg(5'h17, 16);
      push_seg(5'h18, 16);
      push_seg(5'h19, 16);
      frame_q.push_back(flen);
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      @(posedge CLK);
      #1;
      frame_tick = 1'b0;
   endtask

   task automatic wait_done(input string name, input int limit);
      int k = 0;
      while (!frame_done && k < limit) begin
         @(posedge CLK);
         #1;
         k++;
      end
      if (!frame_done) begin
         tests++;
         errors++;
         $display("FAIL %s: got no frame_done within %0d cycles, expected one", name, limit);
      end
      cycles(3);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got simulation still running at 2 ms, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad_plot;
      int bad_cmd;
      int k;

      repeat (3) @(posedge CLK);
      #1;
      check("rst_command", int'(command), 'h16);
      check("rst_plot", int'(plot), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_frame_done", int'(frame_done), 0);
      check("rst_overrun", int'(overrun), 0);
      reset = 1'b0;
      enable = 1'b1;
      cycles(3);
      check("idle_command", int'(command), 'h16);
      check("idle_busy", int'(busy), 0);

      // 1: all-zero note types
      note_types = '0;
      push_frame(16, 16, 2627);
      tick();
      check("t1_busy", int'(busy), 1);
      check("t1_first_cmd", int'(command), 'h14);
      cycles(5);
      check("t1_plot", int'(plot), 1);
      wait_done("t1_done", 3000);
      check("t1_busy_after", int'(busy), 0);
      check("t1_plot_after", int'(plot), 0);

      // 2: note1 small red, note2 big red
      note_types = 45'h19;
      push_frame(81, 169, 2845);
      tick();
      wait_done("t2_done", 3200);

      // 3: big type on note 12 still drawn as a strip
      note_types = 45'd4 << 33;
      push_frame(16, 16, 2627);
      tick();
      wait_done("t3_done", 3000);

      // 4: 100-cycle enable gap mid-CLEAR
      note_types = '0;
      push_frame(16, 16, 2727);
      tick();
      cycles(500);
      enable = 1'b0;
      bad_plot = 0;
      bad_cmd = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge CLK);
         #1;
         if (plot != 1'b0) bad_plot++;
         if (command != 5'h14) bad_cmd++;
      end
      check("t4_gap_plot_high_cycles", bad_plot, 0);
      check("t4_gap_cmd_changes", bad_cmd, 0);
      enable = 1'b1;
      cycles(1);
      check("t4_plot_resumed", int'(plot), 1);
      wait_done("t4_done", 3200);

      // 5: second tick 50 cycles into a frame
      check("t5_overrun_before", int'(overrun), 0);
      push_frame(16, 16, 2627);
      tick();
      cycles(49);
      tick();
      cycles(2);
      check("t5_overrun_set", int'(overrun), 1);
      wait_done("t5_done", 3000);
      check("t5_overrun_sticky", int'(overrun), 1);

      // 6: reset while drawing note 7
      push_frame(16, 16, 2627);
      tick();
      k = 0;
      while (command != 5'h08 && k < 3000) begin
         cycles(1);
         k++;
      end
      check("t6_reached_note7", int'(command), 'h08);
      cycles(10);
      reset = 1'b1;
      #1;
      check("t6_rst_command", int'(command), 'h16);
      check("t6_rst_plot", int'(plot), 0);
      check("t6_rst_busy", int'(busy), 0);
      check("t6_rst_overrun", int'(overrun), 0);
      seg_q.delete();
      frame_q.delete();
      cycles(3);
      reset = 1'b0;
      cycles(2);
      check("t6_idle_after_rst", int'(command), 'h16);
      push_frame(16, 16, 2627);
      tick();
      check("t6_restart_clear", int'(command), 'h14);
      wait_done("t6_done", 3000);

      check("seg_q_drained", seg_q.size(), 0);
      check("frame_q_drained", frame_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
